// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential radix-2 restoring divider, 16-bit dividend by 8-bit divisor.
// One quotient bit per clock; APPROX_LSB low quotient bits are skipped (forced to 0)
// to shorten latency, with the remainder taken from the truncated dividend.
module div_16x8_seq #(
  parameter int APPROX_LSB = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dbz
);

  localparam int K = APPROX_LSB;
  localparam int N = 16 - APPROX_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [4:0]  count_reg;   // iterations still to run
  logic [7:0]  p_reg;       // partial remainder (always < divisor, so 8 bits hold it)
  logic [15:0] a_reg;       // dividend shift register, MSB is the next bit to bring down
  logic [15:0] q_reg;       // quotient bits collected so far, LSB-aligned
  logic [7:0]  d_reg;       // captured divisor

  // One restoring step: bring down the next dividend bit and try to subtract.
  logic [8:0]  t_next;
  logic [7:0]  t_sub;
  logic        qbit_next;
  logic [7:0]  p_next;
  logic [15:0] q_next;

  // Trial subtraction for the current iteration.
  always_comb begin
    t_next    = {p_reg, a_reg[15]};
    qbit_next = (t_next >= {1'b0, d_reg});
    // When the subtraction is taken the result is below d_reg, so 8-bit wraparound is exact.
    t_sub     = t_next[7:0] - d_reg;
    p_next    = qbit_next ? t_sub : t_next[7:0];
    q_next    = {q_reg[14:0], qbit_next};
  end

  assign in_ready = (state_reg == IDLE);

  // Control FSM and datapath registers; outputs update only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      p_reg     <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            d_reg <= divisor;
            a_reg <= dividend;
            p_reg <= '0;
            q_reg <= '0;
            if (divisor == 8'd0) begin
              // Divide by zero short-circuits straight to a saturated result.
              quotient  <= 16'hFFFF;
              remainder <= 8'd0;
              dbz       <= 1'b1;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              count_reg <= 5'(N);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          p_reg     <= p_next;
          q_reg     <= q_next;
          a_reg     <= {a_reg[14:0], 1'b0};
          count_reg <= count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            // Skipped iterations leave zeros below the computed quotient bits.
            quotient  <= q_next << K;
            remainder <= p_next;
            dbz       <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Testbench for div_16x8_seq: an exact (K=0) and a truncated (K=4) instance share
// clock and reset; results are checked against plain integer division.
module tb_div_16x8_seq;

  logic        clk;
  logic        rst;
  logic        iv  [2];
  logic        ir  [2];
  logic [15:0] dv  [2];
  logic [7:0]  dsv [2];
  logic        ov  [2];
  logic        orr [2];
  logic [15:0] qo  [2];
  logic [7:0]  ro  [2];
  logic        zo  [2];

  int total = 0;
  int bad   = 0;

  div_16x8_seq #(.APPROX_LSB(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .dividend(dv[0]), .divisor(dsv[0]),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .quotient(qo[0]), .remainder(ro[0]), .dbz(zo[0])
  );

  div_16x8_seq #(.APPROX_LSB(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .dividend(dv[1]), .divisor(dsv[1]),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .quotient(qo[1]), .remainder(ro[1]), .dbz(zo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One complete transaction on instance s (0: K=0, 1: K=4). Latency is the number of
  // clock edges after the accept edge until out_valid is seen: N normally, 0 for D=0
  // (the result is already valid in the cycle right after the accept).
  task automatic do_op(input int s, input logic [15:0] a, input logic [7:0] d,
                       input int stall, input bit pulse);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          k;
    int          lat;
    int          elat;
    k = (s != 0) ? 4 : 0;
    if (d == 8'd0) begin
      eq = 16'hFFFF; er = 8'd0; ez = 1'b1; elat = 0;
    end else begin
      eq = 16'(((a >> k) / d) << k);
      er = 8'((a >> k) % d);
      ez = 1'b0;
      elat = 16 - k;
    end
    @(negedge clk);
    chk("in_ready_idle", 32'(ir[s]), 32'd1);
    iv[s] = 1'b1; dv[s] = a; dsv[s] = d;
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 0;
    while (!ov[s] && lat < 40) begin
      chk("in_ready_busy", 32'(ir[s]), 32'd0);
      // A stray request with different operands mid-run must be ignored.
      if (pulse && lat == 3) begin
        iv[s] = 1'b1; dv[s] = ~a; dsv[s] = d + 8'd1;
      end else begin
        iv[s] = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    iv[s] = 1'b0;
    chk("latency", 32'(lat), 32'(elat));
    chk("quotient", 32'(qo[s]), 32'(eq));
    chk("remainder", 32'(ro[s]), 32'(er));
    chk("dbz", 32'(zo[s]), 32'(ez));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(ov[s]), 32'd1);
      chk("hold_in_ready", 32'(ir[s]), 32'd0);
      chk("hold_quotient", 32'(qo[s]), 32'(eq));
      chk("hold_remainder", 32'(ro[s]), 32'(er));
    end
    orr[s] = 1'b1;
    @(posedge clk); #1;
    orr[s] = 1'b0;
    chk("valid_cleared", 32'(ov[s]), 32'd0);
    chk("in_ready_back", 32'(ir[s]), 32'd1);
    chk("idle_quotient", 32'(qo[s]), 32'(eq));
    $display("txn K=%0d A=%0d D=%0d -> Q=%0d REM=%0d dbz=%0d lat=%0d (exp Q=%0d REM=%0d)",
             k, a, d, qo[s], ro[s], zo[s], lat, eq, er);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; dv[s] = '0; dsv[s] = '0; orr[s] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_quotient", 32'(qo[0]), 32'd0);
    chk("rst_remainder", 32'(ro[0]), 32'd0);
    chk("rst_dbz", 32'(zo[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_op(0, 16'd1000, 8'd7, 0, 1'b0);
    do_op(1, 16'd1000, 8'd7, 0, 1'b0);
    do_op(0, 16'd1234, 8'd0, 0, 1'b0);
    do_op(1, 16'd1234, 8'd0, 1, 1'b0);
    do_op(0, 16'd65535, 8'd1, 0, 1'b0);
    do_op(0, 16'd65535, 8'd255, 0, 1'b0);
    do_op(0, 16'd5, 8'd200, 0, 1'b0);
    do_op(0, 16'd0, 8'd13, 0, 1'b0);
    do_op(0, 16'd40000, 8'd3, 5, 1'b1);
    do_op(1, 16'd50001, 8'd9, 5, 1'b1);

    // Reset in the middle of a run aborts it immediately.
    @(negedge clk);
    iv[0] = 1'b1; dv[0] = 16'd1000; dsv[0] = 8'd7;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(ov[0]), 32'd0);
    chk("abort_quotient", 32'(qo[0]), 32'd0);
    chk("abort_remainder", 32'(ro[0]), 32'd0);
    chk("abort_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 16'd300, 8'd16, 0, 1'b0);

    // Random sweep on both instances.
    for (int n = 0; n < 40; n++) begin
      do_op(n % 2, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    // Small divisors exercise long quotients.
    for (int n = 0; n < 10; n++) begin
      do_op(n % 2, 16'($urandom_range(0, 65535)), 8'($urandom_range(1, 4)), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
